spi_slave_bytes: RTL
====================

SPI_SLAVE_BYTES -- requirements
Module: spi_slave_bytes

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer flip-flops on sck, mosi and ncs (legal range 2..3).
REQ-002 Port clk  input  1  system clock; all logic rises on posedge clk.
REQ-003 Port nreset  input  1  reset, asynchronous and active-low.
REQ-004 Port sck  input  1  SPI clock from the master, asynchronous to clk.
REQ-005 Port mosi  input  1  SPI data from the master, asynchronous to clk.
REQ-006 Port ncs  input  1  SPI chip select from the master, active-low, asynchronous to clk.
REQ-007 Port miso  output  1  SPI data to the master; never tristated.
REQ-008 Port rx_data  output  8  last complete received byte.
REQ-009 Port rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-010 Port rx_first  output  1  qualifies rx_valid; high for the first byte of a frame.
REQ-011 Port tx_data  input  8  next byte to transmit.
REQ-012 Port tx_load  input  1  writes tx_data into the holding register when tx_empty=1; ignored otherwise.
REQ-013 Port tx_empty  output  1  holding register is free.
REQ-014 Port tx_underrun  output  1  one-cycle pulse when a byte boundary finds the holding register empty.
REQ-015 Port frame_start, frame_end  output  1 each  one-cycle pulses on synchronized ncs fall and ncs rise.
REQ-016 Port busy  output  1  high while synchronized ncs is low.

Function
REQ-017 The protocol SHALL be SPI mode 0, MSB first: sample mosi on the sck rise, change miso after the sck fall, 8-bit bytes, frame delimited by ncs low.
REQ-018 The block SHALL operate correctly when sck high and sck low phases each last at least 4 clk periods; faster sck is unsupported.
REQ-019 sck, mosi and ncs SHALL each pass through SYNC_STAGES flops; edges SHALL be detected on the synchronized signals only.
REQ-020 The FSM SHALL have states IDLE (ncs high) and SHIFT (ncs low); IDLE->SHIFT on the synchronized ncs fall, and SHIFT->IDLE on the synchronized ncs rise.
REQ-021 On IDLE->SHIFT: pulse frame_start; clear the 3-bit bit counter; set the first-byte flag; load the tx shift register from the holding register if full (tx_empty->1), else load 0x00 and pulse tx_underrun.
REQ-022 On each synchronized sck rise in SHIFT: shift mosi into the rx shift register LSB; increment the bit counter modulo 8.
REQ-023 When the bit counter wraps 7->0: rx_data <= the assembled byte; pulse rx_valid; rx_first = first-byte flag; then clear the first-byte flag.
REQ-024 rx_valid SHALL assert exactly SYNC_STAGES+1 clk cycles after the 8th sck rise at the pin.
REQ-025 On each synchronized sck fall in SHIFT with bit counter != 0: shift the tx register left by one.
REQ-026 On a synchronized sck fall with bit counter == 0 (byte boundary, not the first fall of the frame): reload the tx shift register from the holding register, with the same underrun rule as REQ-021.
REQ-027 miso SHALL equal tx shift register bit 7 while busy=1, and 0 while busy=0.
REQ-028 tx_load coinciding with a holding-to-shift transfer SHALL be accepted; the holding register then holds the new byte and tx_empty stays 0.
REQ-029 An ncs rise mid-byte SHALL discard the partial byte (no rx_valid), pulse frame_end, and return to IDLE; the holding register contents SHALL be preserved.
REQ-030 sck edges while synchronized ncs is high SHALL be ignored.
REQ-031 ncs rise and sck rise in the same synchronized cycle: ncs SHALL win, and the sck edge SHALL be ignored.

Reset
REQ-032 nreset low SHALL asynchronously force: IDLE; all synchronizer flops to the idle level (sck=0, mosi=0, ncs=1); miso=0, rx_data=0x00, rx_valid=0, rx_first=0, tx_empty=1, tx_underrun=0, frame_start=0, frame_end=0, busy=0; holding, shift and bit-counter registers cleared.
REQ-033 A reset asserted mid-frame SHALL abort the frame without a frame_end pulse; after release, the block SHALL wait for a fresh ncs fall.

Verification
REQ-034 Reset: nreset=0 with random inputs -> all outputs at REQ-032 values; release with ncs=1 -> no pulses.
REQ-035 Load 0xA5, then master sends 0x3C with 8-clk sck period -> miso bits 1,0,1,0,0,1,0,1; rx_data=0x3C with rx_first=1; tx_empty=1 after frame_start.
REQ-036 Three-byte frame 0x00,0x01,0xFF, with tx 0x11,0x22,0x33 each loaded on tx_empty -> rx_valid x3 (rx_first only on the first); miso carries 0x11,0x22,0x33; no tx_underrun.
REQ-037 Frame with no tx_load -> miso all zero; tx_underrun pulses at frame start and at each byte boundary.
REQ-038 ncs rises after 5 bits -> no rx_valid, one frame_end; next frame receives 0x81 correctly.
REQ-039 Assert nreset mid-byte, release, then send 0x5A -> rx_data=0x5A with rx_first=1; no frame_end from the aborted frame.

Source files
------------

// File: rtl/spi_slave_bytes.sv
// SPI mode-0 byte slave: synchronizes sck/mosi/ncs into the clk domain and
// exchanges MSB-first bytes through an rx register and a one-deep tx holding register.
module spi_slave_bytes #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       sck,
    input  logic       mosi,
    input  logic       ncs,
    output logic       miso,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_empty,
    output logic       tx_underrun,
    output logic       frame_start,
    output logic       frame_end,
    output logic       busy
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] ncs_sync_q;
    logic                   sck_prev_q;
    logic                   ncs_prev_q;
    logic [SYNC_STAGES:0]   fill_q;
    logic                   armed_q;

    logic       sck_s;
    logic       mosi_s;
    logic       ncs_s;
    logic       sck_rise;
    logic       sck_fall;
    logic       ncs_fall;
    logic       ncs_rise;

    logic [0:0] state_q,       state_d;
    logic [2:0] bit_cnt_q,     bit_cnt_d;
    logic       first_q,       first_d;
    logic [6:0] rx_shift_q,    rx_shift_d;
    logic [7:0] rx_data_q,     rx_data_d;
    logic       rx_valid_q,    rx_valid_d;
    logic       rx_first_q,    rx_first_d;
    logic [7:0] hold_q,        hold_d;
    logic       tx_empty_q,    tx_empty_d;
    logic [7:0] tx_shift_q,    tx_shift_d;
    logic       tx_underrun_q, tx_underrun_d;
    logic       frame_start_q, frame_start_d;
    logic       frame_end_q,   frame_end_d;
    logic       xfer;

    // Stage 0: synchronizer chains and edge history
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            ncs_sync_q  <= '1;
            sck_prev_q  <= 1'b0;
            ncs_prev_q  <= 1'b1;
            fill_q      <= '0;
            armed_q     <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
            sck_prev_q  <= sck_s;
            ncs_prev_q  <= ncs_s;
            fill_q      <= {fill_q[SYNC_STAGES-1:0], 1'b1};
            armed_q     <= armed_q | (fill_q[SYNC_STAGES] & ncs_s);
        end
    end

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign ncs_s    = ncs_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    // A chip select already low when reset releases must not start a frame
    assign ncs_fall = armed_q & ncs_prev_q & ~ncs_s;
    assign ncs_rise = ncs_s & ~ncs_prev_q;

    // Stage 1: frame FSM, shift registers and tx holding register
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        first_d       = first_q;
        rx_shift_d    = rx_shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        rx_first_d    = rx_first_q;
        hold_d        = hold_q;
        tx_empty_d    = tx_empty_q;
        tx_shift_d    = tx_shift_q;
        tx_underrun_d = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        xfer          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ncs_fall) begin
                    state_d       = ST_SHIFT;
                    frame_start_d = 1'b1;
                    bit_cnt_d     = 3'd0;
                    first_d       = 1'b1;
                    xfer          = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (ncs_rise) begin
                    state_d     = ST_IDLE;
                    frame_end_d = 1'b1;
                    bit_cnt_d   = 3'd0;
                end else begin
                    if (sck_rise) begin
                        rx_shift_d = {rx_shift_q[5:0], mosi_s};
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d  = {rx_shift_q, mosi_s};
                            rx_valid_d = 1'b1;
                            rx_first_d = first_q;
                            first_d    = 1'b0;
                        end
                    end
                    // A fall at count 0 while no byte has completed is a stray
                    // edge from sck being high at ncs fall, not a byte boundary
                    if (sck_fall) begin
                        if (bit_cnt_q != 3'd0) begin
                            tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        end else if (!first_q) begin
                            xfer = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (xfer) begin
            if (!tx_empty_q) begin
                tx_shift_d = hold_q;
                tx_empty_d = 1'b1;
            end else begin
                tx_shift_d    = 8'h00;
                tx_underrun_d = 1'b1;
            end
        end

        // A transfer frees the holding register in the same cycle it is refilled
        if (tx_load && (tx_empty_q || xfer)) begin
            hold_d     = tx_data;
            tx_empty_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= 3'd0;
            first_q       <= 1'b0;
            rx_shift_q    <= 7'd0;
            rx_data_q     <= 8'h00;
            rx_valid_q    <= 1'b0;
            rx_first_q    <= 1'b0;
            hold_q        <= 8'h00;
            tx_empty_q    <= 1'b1;
            tx_shift_q    <= 8'h00;
            tx_underrun_q <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            first_q       <= first_d;
            rx_shift_q    <= rx_shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            rx_first_q    <= rx_first_d;
            hold_q        <= hold_d;
            tx_empty_q    <= tx_empty_d;
            tx_shift_q    <= tx_shift_d;
            tx_underrun_q <= tx_underrun_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
        end
    end

    // Stage 2: outputs
    assign busy        = (state_q == ST_SHIFT);
    assign miso        = busy & tx_shift_q[7];
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_first    = rx_first_q;
    assign tx_empty    = tx_empty_q;
    assign tx_underrun = tx_underrun_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;

endmodule
